// File: rtl/seq_div_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package seq_div_pkg;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  localparam int DIVIDEND_W_DEF = 24;
  localparam int DIVISOR_W_DEF  = 12;

  // Iteration counter width; the counter must also reach the final commit value w.
  function automatic int CNT_W(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module div_step
  import seq_div_pkg::*;
#(
  parameter int DIVISOR_W = DIVISOR_W_DEF
) (
  input  logic [DIVISOR_W:0]   p,
  input  logic                 dividend_bit,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W:0]   p_next,
  output logic                 q_bit
);

  logic [DIVISOR_W+1:0] p_shift;
  logic [DIVISOR_W:0]   t;

  assign p_shift = {p, dividend_bit};
  // Only the low bits of the difference matter once the trial subtraction is known to succeed.
  assign t       = p_shift[DIVISOR_W:0] - {1'b0, divisor};
  assign q_bit   = (p_shift >= {2'b00, divisor});
  assign p_next  = q_bit ? t : p_shift[DIVISOR_W:0];

endmodule

// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider with Start/Done handshake.
// Optional macro SIGNED_DIV_EN: two's-complement operands with a FIX sign-correction state.
module seq_divider
  import seq_div_pkg::*;
#(
  parameter int DIVIDEND_W = DIVIDEND_W_DEF,
  parameter int DIVISOR_W  = DIVISOR_W_DEF
) (
  input  logic                  Clock,
  input  logic                  Aclr_n,
  input  logic                  ClkEn,
  input  logic                  Start,
  input  logic [DIVIDEND_W-1:0] Dividend,
  input  logic [DIVISOR_W-1:0]  Divisor,
  output logic                  Busy,
  output logic                  Done,
  output logic [DIVIDEND_W-1:0] Quotient,
  output logic [DIVISOR_W-1:0]  Remainder,
  output logic                  DivZero,
  output state_t                dbg_state
);

  // Handshake: Start is taken on an enabled edge whenever Busy=0 (IDLE or DONE);
  // Done is high for exactly the DONE state and marks Quotient/Remainder/DivZero valid.
  localparam int CW = CNT_W(DIVIDEND_W);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIVIDEND_W);

  state_t                state, state_next;
  logic [CW-1:0]         cnt;
  logic [DIVIDEND_W-1:0] dvd_sr;
  logic [DIVISOR_W-1:0]  dsr;
  logic [DIVISOR_W:0]    p, p_next;
  logic                  q_bit;
  logic                  div_zero;
  logic                  accept;
`ifdef SIGNED_DIV_EN
  logic                  neg_q, neg_r;
  logic [DIVISOR_W-1:0]  dvd_lo;
`endif

  div_step #(.DIVISOR_W(DIVISOR_W)) u_step (
    .p            (p),
    .dividend_bit (dvd_sr[DIVIDEND_W-1]),
    .divisor      (dsr),
    .p_next       (p_next),
    .q_bit        (q_bit)
  );

  assign accept    = Start && (state == IDLE || state == DONE);
  assign Busy      = (state == RUN) || (state == FIX);
  assign Done      = (state == DONE);
  assign dbg_state = state;

  always_ff @(posedge Clock or negedge Aclr_n) begin
    if (!Aclr_n) state <= IDLE;
    else if (ClkEn) state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: state_next = Start ? RUN : IDLE;
`ifdef SIGNED_DIV_EN
      RUN:        if (cnt == CNT_LAST) state_next = FIX;
      FIX:        state_next = DONE;
`else
      RUN:        if (cnt == CNT_LAST) state_next = DONE;
`endif
      default:    state_next = IDLE;
    endcase
  end

  // Counts 0..DIVIDEND_W-1 perform the steps; the final count commits the result.
  always_ff @(posedge Clock or negedge Aclr_n) begin
    if (!Aclr_n) begin
      cnt       <= '0;
      dvd_sr    <= '0;
      dsr       <= '0;
      p         <= '0;
      div_zero  <= 1'b0;
      Quotient  <= '0;
      Remainder <= '0;
      DivZero   <= 1'b0;
`ifdef SIGNED_DIV_EN
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      dvd_lo    <= '0;
`endif
    end else if (ClkEn) begin
      if (accept) begin
        cnt      <= '0;
        p        <= '0;
        div_zero <= (Divisor == '0);
`ifdef SIGNED_DIV_EN
        dvd_sr   <= Dividend[DIVIDEND_W-1] ? -Dividend : Dividend;
        dsr      <= Divisor[DIVISOR_W-1] ? -Divisor : Divisor;
        neg_q    <= Dividend[DIVIDEND_W-1] ^ Divisor[DIVISOR_W-1];
        neg_r    <= Dividend[DIVIDEND_W-1];
        dvd_lo   <= Dividend[DIVISOR_W-1:0];
`else
        dvd_sr   <= Dividend;
        dsr      <= Divisor;
`endif
      end else if (state == RUN) begin
        cnt <= cnt + CW'(1);
        if (cnt != CNT_LAST) begin
          p      <= p_next;
          dvd_sr <= {dvd_sr[DIVIDEND_W-2:0], q_bit};
        end
`ifndef SIGNED_DIV_EN
        else begin
          // A zero divisor naturally yields all-ones quotient and the low dividend bits.
          Quotient  <= dvd_sr;
          Remainder <= p[DIVISOR_W-1:0];
          DivZero   <= div_zero;
        end
`endif
      end
`ifdef SIGNED_DIV_EN
      else if (state == FIX) begin
        DivZero <= div_zero;
        if (div_zero) begin
          Quotient  <= '1;
          Remainder <= dvd_lo;
        end else begin
          Quotient  <= neg_q ? -dvd_sr : dvd_sr;
          Remainder <= neg_r ? -p[DIVISOR_W-1:0] : p[DIVISOR_W-1:0];
        end
      end
`endif
    end
  end

endmodule
